// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          cfg_divider,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [PW:0]          count_q, count_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 ser_q, ser_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // ---------------- FIFO ----------------
  assign in_ready = (count_q != FULL_C);
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------- Serialiser ----------------
  assign div_eff = (cfg_divider < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_divider;
  assign bit_end = (cnt_q == div_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    div_d   = div_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ser_d   = ser_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        ser_d = 1'b1;
        pop   = (count_q != '0);
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          ser_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            ser_d   = parity_q;
`else
            state_d = S_STOP;
            ser_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            ser_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          ser_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          ser_d   = 1'b1;
          pop     = (count_q != '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase

    // Loading a new byte is shared by the idle pop and the back-to-back pop at end of STOP.
    if (pop) begin
      state_d = S_START;
      shift_d = mem_q[rptr_q];
      div_d   = div_eff;
      cnt_d   = '0;
      idx_d   = '0;
      ser_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rptr_q];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(2);
      shift_q <= '0;
      idx_q   <= '0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ser_tx     = ser_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-and-frame-timer reference model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cfg_divider;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ser_tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(
    .FIFO_DEPTH(DEPTH),
    .DIV_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_divider(cfg_divider),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: queue of accepted bytes, plus the byte on the line and
  // the number of clocks elapsed since its start bit began.
  logic [7:0]  q[$];
  bit          m_active = 1'b0;
  logic [7:0]  m_byte   = '0;
  int unsigned m_div    = 2;
  int unsigned m_t      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ser();
    int unsigned b;
    if (!m_active) return 1'b1;
    b = m_t / m_div;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit do_push;
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_t      = 0;
      return;
    end
    do_push = in_valid && (q.size() < DEPTH);
    if (m_active) begin
      m_t++;
      if (m_t == NBITS * m_div) m_active = 1'b0;
    end
    if (!m_active && q.size() != 0) begin
      m_byte   = q.pop_front();
      m_div    = (cfg_divider < 2) ? 2 : cfg_divider;
      m_t      = 0;
      m_active = 1'b1;
    end
    if (do_push) q.push_back(in_data);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("ser_tx",     32'(ser_tx),     32'(exp_ser()));
    check_eq("busy",       32'(busy),       32'(m_active || q.size() != 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    check_eq("in_ready",   32'(in_ready),   32'(q.size() != DEPTH));
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20000 && (m_active || q.size() != 0); i++) cycle();
    cycle();
    check_eq("drain_idle", 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cfg_divider = 32'd4;
    in_data     = '0;
    in_valid    = 1'b0;
    @(negedge clk);
    do_reset();
    check_eq("rst_ser", 32'(ser_tx), 32'(1));
    check_eq("rst_cnt", 32'(fifo_count), 32'(0));

    // Single 0x55 at div 4: start bit follows the accept by one edge.
    push_byte(8'h55);
    check_eq("t1_pop_latency", 32'(ser_tx), 32'(1));
    cycle();
    check_eq("t1_start_bit", 32'(ser_tx), 32'(0));
    drain();

    // Burst into a busy line: FIFO fills, in_ready drops, nothing lost.
    cfg_divider = 32'd8;
    in_valid    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = 8'($urandom);
      cycle();
    end
    check_eq("t2_full", 32'(fifo_count), 32'(DEPTH));
    drain();

    // Back-to-back frames with no idle gap.
    push_byte(8'hA0);
    push_byte(8'h0F);
    drain();

    // Reset mid-DATA with bytes queued.
    cfg_divider = 32'd4;
    push_byte(8'h3C);
    push_byte(8'h5A);
    push_byte(8'hC3);
    push_byte(8'h99);
    repeat (10) cycle();
    do_reset();
    check_eq("t4_ser", 32'(ser_tx), 32'(1));
    check_eq("t4_busy", 32'(busy), 32'(0));
    repeat (60) cycle();

    // Divider floor and mid-frame divider change.
    cfg_divider = 32'd0;
    push_byte(8'hE7);
    drain();
    cfg_divider = 32'd1;
    push_byte(8'h18);
    drain();
    cfg_divider = 32'd4;
    push_byte(8'h6D);
    repeat (9) cycle();
    cfg_divider = 32'd6;
    push_byte(8'hB2);
    drain();

    // Parity-relevant bytes (odd and even popcount).
    cfg_divider = 32'd4;
    push_byte(8'h07);
    push_byte(8'h03);
    drain();

    // Random traffic with divider changes and rare resets.
    for (int i = 0; i < 6000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) cfg_divider = 32'($urandom_range(0, 5));
      reset = ($urandom_range(0, 1999) == 0);
      cycle();
    end
    reset = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
